sys2_feeder: RTL

SYS2_FEEDER -- requirements
Module: sys2_feeder

---
 rtl/sys2_pkg.sv | 89 ++++++++
 rtl/sys2_feeder_if.sv | 57 +++++
 rtl/sys2_feeder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sys2_pkg.sv
// ---------------------------------------------------------------------------
// sys2_pkg
//   Shared definitions for the 2x2 FP32 systolic feeder, the array it drives
//   and the bench that checks both.
//
//   Contents:
//     FP32_W       - width of one FP32 operand (32)
//     FEED_STEPS   - number of skewed feed steps per run (3)
//     FP32_ZERO    - +0.0 bit pattern driven on idle feed lanes
//     sys2_state_e - feeder FSM state encoding
//     sys2_ops_t   - the eight captured operands of one run
//     sys2_feed_t  - the four edge feeds (W0, W1, N0, N1)
//     skew_feed()  - step-counter to feed mapping (3-entry case)
// ---------------------------------------------------------------------------
package sys2_pkg;

    localparam int FP32_W     = 32;
    localparam int FEED_STEPS = 3;

    localparam logic [FP32_W-1:0] FP32_ZERO = '0;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sys2_state_e;

    // Row-major operand snapshot; bit patterns only, never interpreted.
    typedef struct packed {
        fp32_t a00;
        fp32_t a01;
        fp32_t a10;
        fp32_t a11;
        fp32_t b00;
        fp32_t b01;
        fp32_t b10;
        fp32_t b11;
    } sys2_ops_t;

    // West lanes carry rows of A, north lanes carry columns of B.
    typedef struct packed {
        fp32_t w0;
        fp32_t w1;
        fp32_t n0;
        fp32_t n1;
    } sys2_feed_t;

    // Skew schedule. Row/column 1 lag row/column 0 by one step so that each
    // PE sees a matching A/B pair after the array's internal one-cycle hops:
    //   step 0 : W0=a00            N0=b00
    //   step 1 : W0=a01 W1=a10     N0=b10 N1=b01
    //   step 2 :        W1=a11            N1=b11
    // Any other step value yields all-zero lanes.
    function automatic sys2_feed_t skew_feed(input logic [1:0] step,
                                             input sys2_ops_t ops);
        sys2_feed_t f;
        f.w0 = FP32_ZERO;
        f.w1 = FP32_ZERO;
        f.n0 = FP32_ZERO;
        f.n1 = FP32_ZERO;
        case (step)
            2'd0: begin
                f.w0 = ops.a00;
                f.n0 = ops.b00;
            end
            2'd1: begin
                f.w0 = ops.a01;
                f.w1 = ops.a10;
                f.n0 = ops.b10;
                f.n1 = ops.b01;
            end
            2'd2: begin
                f.w1 = ops.a11;
                f.n1 = ops.b11;
            end
            default: begin
                f.w0 = FP32_ZERO;
                f.w1 = FP32_ZERO;
                f.n0 = FP32_ZERO;
                f.n1 = FP32_ZERO;
            end
        endcase
        return f;
    endfunction

endpackage : sys2_pkg

// File: rtl/sys2_feeder_if.sv
// ---------------------------------------------------------------------------
// sys2_feeder_if
//   Bundles the feeder's request/operand/feed signals so a driver (bench or
//   upstream controller) and the feeder side can be wired as one object.
//
//   Handshake: start is a request that is taken only on an edge where the
//   feeder is idle (busy=0 and done=0); while busy=1 or done=1 the request is
//   ignored and the operands are don't-care. The operands need only be
//   stable on the accepting edge. done is a one-cycle pulse that marks the
//   array results as final; busy falls on the same edge done rises.
//
//   Signals:
//     start                  - run request (driver -> feeder)
//     a00_i..a11_i           - matrix A, row-major, FP32 bit patterns
//     b00_i..b11_i           - matrix B, row-major, FP32 bit patterns
//     W0_o, W1_o             - west-edge feeds (feeder -> array)
//     N0_o, N1_o             - north-edge feeds (feeder -> array)
//     busy, done             - run status (feeder -> driver)
// ---------------------------------------------------------------------------
interface sys2_feeder_if;
    import sys2_pkg::*;

    logic  start;
    fp32_t a00_i;
    fp32_t a01_i;
    fp32_t a10_i;
    fp32_t a11_i;
    fp32_t b00_i;
    fp32_t b01_i;
    fp32_t b10_i;
    fp32_t b11_i;
    fp32_t W0_o;
    fp32_t W1_o;
    fp32_t N0_o;
    fp32_t N1_o;
    logic  busy;
    logic  done;

    // Driver side: issues requests and operands, observes feeds and status.
    modport master (
        output start,
        output a00_i, a01_i, a10_i, a11_i,
        output b00_i, b01_i, b10_i, b11_i,
        input  W0_o, W1_o, N0_o, N1_o,
        input  busy, done
    );

    // Feeder side.
    modport slave (
        input  start,
        input  a00_i, a01_i, a10_i, a11_i,
        input  b00_i, b01_i, b10_i, b11_i,
        output W0_o, W1_o, N0_o, N1_o,
        output busy, done
    );

endinterface : sys2_feeder_if

// File: rtl/sys2_feeder.sv
// ---------------------------------------------------------------------------
// sys2_feeder
//   Captures a 2x2 FP32 operand pair (A, B) on start and streams it into a
//   2x2 output-stationary systolic array as skewed west (A rows) and north
//   (B columns) feeds, then idles the feeds for DRAIN_CYCLES cycles so the
//   array can finish accumulating, then pulses done.
//
//   Timeline relative to the accepting edge E0:
//     E0, E0+1, E0+2   : feed steps 0, 1, 2            (state FEED)
//     E0+3             : feeds zero, DRAIN begins       (DRAIN_CYCLES cycles)
//     E0+3+DRAIN_CYCLES: done=1 for one cycle           (state DONE)
//     next edge        : back to IDLE; a new start is taken from here on
//
//   Parameters:
//     DRAIN_CYCLES - idle-input cycles after the last operand (>= 1)
//
//   Ports:
//     clk                    - single clock, rising edge
//     reset                  - synchronous, active-low
//     start                  - run request, honoured only in IDLE
//     a00_i..a11_i           - matrix A, row-major, FP32
//     b00_i..b11_i           - matrix B, row-major, FP32
//     W0_o, W1_o             - west-edge feeds to array W0_i/W1_i
//     N0_o, N1_o             - north-edge feeds to array N0_i/N1_i
//     busy                   - high in FEED and DRAIN
//     done                   - one-cycle pulse when array outputs are final
//     state_o                - current FSM state, for observation only
//
//   Every output comes straight from a flop; operands are pure bit patterns
//   and are never interpreted (NaN, Inf, -0 and denormals pass verbatim).
// ---------------------------------------------------------------------------
module sys2_feeder
    import sys2_pkg::*;
#(
    parameter int DRAIN_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,

    input  logic [FP32_W-1:0] a00_i,
    input  logic [FP32_W-1:0] a01_i,
    input  logic [FP32_W-1:0] a10_i,
    input  logic [FP32_W-1:0] a11_i,
    input  logic [FP32_W-1:0] b00_i,
    input  logic [FP32_W-1:0] b01_i,
    input  logic [FP32_W-1:0] b10_i,
    input  logic [FP32_W-1:0] b11_i,

    output logic [FP32_W-1:0] W0_o,
    output logic [FP32_W-1:0] W1_o,
    output logic [FP32_W-1:0] N0_o,
    output logic [FP32_W-1:0] N1_o,

    output logic              busy,
    output logic              done,
    output sys2_state_e       state_o
);

    // Drain counter is sized to hold DRAIN_CYCLES; it only ever counts up to
    // DRAIN_CYCLES-1, so it never wraps.
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [1:0]         STEP_LAST  = 2'(FEED_STEPS - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    sys2_state_e         state_q, state_d;
    logic [1:0]          step_q,  step_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    sys2_ops_t           ops_q,   ops_d;
    sys2_feed_t          feed_q,  feed_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    // Live operand inputs, gathered so the accepting edge can present step 0
    // straight from the ports while the same values are being captured.
    sys2_ops_t           ops_in;

    assign ops_in.a00 = a00_i;
    assign ops_in.a01 = a01_i;
    assign ops_in.a10 = a10_i;
    assign ops_in.a11 = a11_i;
    assign ops_in.b00 = b00_i;
    assign ops_in.b01 = b01_i;
    assign ops_in.b10 = b10_i;
    assign ops_in.b11 = b11_i;

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        drain_d   = drain_q;
        ops_d     = ops_q;
        feed_d.w0 = FP32_ZERO;
        feed_d.w1 = FP32_ZERO;
        feed_d.n0 = FP32_ZERO;
        feed_d.n1 = FP32_ZERO;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Capture and present step 0 on the same edge.
                    ops_d   = ops_in;
                    step_d  = 2'd0;
                    feed_d  = skew_feed(2'd0, ops_in);
                    state_d = ST_FEED;
                end
            end

            ST_FEED: begin
                // step_q names the step currently on the outputs.
                if (step_q == STEP_LAST) begin
                    step_d  = 2'd0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    step_d  = step_q + 2'd1;
                    feed_d  = skew_feed(step_q + 2'd1, ops_q);
                end
            end

            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                step_d  = 2'd0;
                drain_d = '0;
            end
        endcase

        // Status flags are registered copies of the state being entered, so
        // busy/done line up with state_q on the following cycle.
        busy_d = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            step_q    <= 2'd0;
            drain_q   <= '0;
            ops_q     <= '0;
            feed_q.w0 <= FP32_ZERO;
            feed_q.w1 <= FP32_ZERO;
            feed_q.n0 <= FP32_ZERO;
            feed_q.n1 <= FP32_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            drain_q   <= drain_d;
            ops_q     <= ops_d;
            feed_q    <= feed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign W0_o    = feed_q.w0;
    assign W1_o    = feed_q.w1;
    assign N0_o    = feed_q.n0;
    assign N1_o    = feed_q.n1;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule : sys2_feeder
